// File: rtl/mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq_ctrl
// Description : Multi-cycle multiply/divide sequencer for the EX stage.
//               It handles MULTU, DIVU, MTHI and MTLO, and it owns the HI/LO
//               registers. Multiplication is a 32-step shift-add loop.
//               Division is a 32-step restoring loop. While an operation
//               iterates, busy is raised so the pipeline stalls.
//               Optional macro MDU_SIGNED_EN adds signed MULT/DIV. Operands
//               are converted to magnitudes when the command is accepted,
//               and a one-cycle FIX state then corrects the result signs.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic             md_signed,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MUL  = 3'd1;
    localparam logic [2:0] c_DIV  = 3'd2;
`ifdef MDU_SIGNED_EN
    localparam logic [2:0] c_FIX  = 3'd3;
`endif
    localparam logic [2:0] c_DONE = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_LAST = {CNT_W{1'b1}};

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    // Holds the multiplicand for MUL, or the divisor for DIV.
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    // For MUL this pair is {product high, multiplier/product low}.
    // For DIV it is {remainder, dividend/quotient}.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;

`ifdef MDU_SIGNED_EN
    logic             sgn_q,     sgn_d;
    logic             is_div_q,  is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_rs_neg   = md_signed & rs_data[WIDTH-1];
    assign w_rt_neg   = md_signed & rt_data[WIDTH-1];
    assign w_prod     = {acc_hi_q, acc_lo_q};
    assign w_prod_neg = -w_prod;
`endif

    // Multiplier step: conditionally add with carry, then shift the chain right.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_mul_sum = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q})
                                   : {1'b0, acc_hi_q};
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Divider step: shift {rem, quo} left and trial-subtract the divisor.
    // The shifted remainder can need WIDTH+1 bits. The extra top bit of
    // the difference is the borrow, which means "divisor did not fit".
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign w_div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_div_diff = {1'b0, w_div_sh} - {2'b00, opnd_q};
    assign w_div_ge   = ~w_div_diff[WIDTH+1];
    assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_quo  = {acc_lo_q[WIDTH-2:0], w_div_ge};

    // When the step succeeds, the difference is below the divisor, so its
    // top value bit is always zero. md_signed is only consumed in signed builds.
    logic w_unused_bits;
    assign w_unused_bits = ^{md_signed, w_div_diff[WIDTH]};

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
`ifdef MDU_SIGNED_EN
        sgn_d     = sgn_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            c_IDLE, c_DONE: begin
                state_d = c_IDLE;
                if (start) begin
                    case (md_op)
                        2'd0, 2'd1: begin
                            cnt_d    = '0;
                            acc_hi_d = '0;
                            state_d  = (md_op == 2'd0) ? c_MUL : c_DIV;
`ifdef MDU_SIGNED_EN
                            opnd_d    = w_rt_neg ? -rt_data : rt_data;
                            acc_lo_d  = w_rs_neg ? -rs_data : rs_data;
                            sgn_d     = md_signed;
                            is_div_d  = md_op[0];
                            neg_res_d = w_rs_neg ^ w_rt_neg;
                            neg_rem_d = w_rs_neg;
`else
                            opnd_d   = rt_data;
                            acc_lo_d = rs_data;
`endif
                        end
                        2'd2:    hi_d = rs_data;
                        default: lo_d = rs_data;
                    endcase
                end
            end
            c_MUL: begin
                acc_hi_d = w_mul_hi;
                acc_lo_d = w_mul_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) begin
                    hi_d    = w_mul_hi;
                    lo_d    = w_mul_lo;
                    state_d = c_DONE;
`ifdef MDU_SIGNED_EN
                    if (sgn_q) begin
                        hi_d    = hi_q;
                        lo_d    = lo_q;
                        state_d = c_FIX;
                    end
`endif
                end
            end
            c_DIV: begin
                acc_hi_d = w_div_rem;
                acc_lo_d = w_div_quo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_CNT_LAST) begin
                    hi_d    = w_div_rem;
                    lo_d    = w_div_quo;
                    state_d = c_DONE;
`ifdef MDU_SIGNED_EN
                    if (sgn_q) begin
                        hi_d    = hi_q;
                        lo_d    = lo_q;
                        state_d = c_FIX;
                    end
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            c_FIX: begin
                state_d = c_DONE;
                if (is_div_q) begin
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? w_prod_neg : w_prod;
                end
            end
`endif
            default: state_d = c_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
`ifdef MDU_SIGNED_EN
            sgn_q     <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
`ifdef MDU_SIGNED_EN
            sgn_q     <= sgn_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

`ifdef MDU_SIGNED_EN
    assign busy = (state_q == c_MUL) || (state_q == c_DIV) || (state_q == c_FIX);
`else
    assign busy = (state_q == c_MUL) || (state_q == c_DIV);
`endif
    assign done = (state_q == c_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq_ctrl
// Description : Directed self-checking bench for mdu_seq_ctrl. It covers
//               MULTU, DIVU, divide by zero, MTHI/MTLO, back-to-back issue,
//               and ignored start while busy. It also covers reset during
//               iteration and, when MDU_SIGNED_EN is set, signed operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic        md_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] old_hi;
    logic [31:0] old_lo;

    mdu_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .md_signed (md_signed),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge. Inputs are then scrambled, so any
    // later use of the live operands shows up as a wrong result.
    task automatic issue(input logic [1:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        old_hi    = hi;
        old_lo    = lo;
        md_op     = op;
        md_signed = sgn;
        rs_data   = a;
        rt_data   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        rs_data = ~a;
        rt_data = ~b;
    endtask

    // Count cycles until done. Check the latency, the busy span and that
    // hi/lo hold, then check the result. Returns while still in the DONE cycle.
    task automatic wait_done(input string tag, input int lat, input int poke,
                             input logic [31:0] eh, input logic [31:0] el);
        int   cyc  = 1;
        int   nb   = 0;
        logic hold = 1'b1;
        while (done !== 1'b1 && cyc < 80) begin
            if (busy === 1'b1) nb++;
            if (hi !== old_hi || lo !== old_lo) hold = 1'b0;
            if (cyc == poke) begin
                start = 1'b1;
                md_op = 2'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(cyc), 64'(lat));
        chk({tag, "/busy_cycles"}, 64'(nb), 64'(lat - 1));
        chk({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "/hold"}, 64'(hold), 64'd1);
        chk({tag, "/hi"}, 64'(hi), 64'(eh));
        chk({tag, "/lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        md_op     = 2'd0;
        md_signed = 1'b0;
        rs_data   = 32'h0;
        rt_data   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/hi", 64'(hi), 64'd0);
        chk("reset/lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MULTU max * 2, followed by a check that done lasts one cycle.
        issue(2'd0, 1'b0, 32'hFFFFFFFF, 32'h00000002);
        wait_done("mul_ff_x2", 33, 0, 32'h00000001, 32'hFFFFFFFE);
        @(posedge clk); #1;
        chk("mul_ff_x2/done_one_cycle", 64'(done), 64'd0);
        chk("mul_ff_x2/idle_busy", 64'(busy), 64'd0);

        // DIVU 100/7 with a MULTU start poked mid-iteration.
        issue(2'd1, 1'b0, 32'd100, 32'd7);
        wait_done("div_100_7", 33, 10, 32'd2, 32'd14);
        @(posedge clk); #1;

        // Divide by zero.
        issue(2'd1, 1'b0, 32'h12345678, 32'h0);
        wait_done("div_by_zero", 33, 0, 32'h12345678, 32'hFFFFFFFF);
        @(posedge clk); #1;

        // MTHI then MTLO on consecutive cycles.
        md_op = 2'd2; rs_data = 32'hDEADBEEF; start = 1'b1;
        @(posedge clk); #1;
        chk("mthi/hi", 64'(hi), 64'hDEADBEEF);
        chk("mthi/busy", 64'(busy), 64'd0);
        chk("mthi/done", 64'(done), 64'd0);
        md_op = 2'd3; rs_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo/lo", 64'(lo), 64'd5);
        chk("mtlo/hi", 64'(hi), 64'hDEADBEEF);
        chk("mtlo/busy", 64'(busy), 64'd0);
        chk("mtlo/done", 64'(done), 64'd0);

        // Back-to-back issue: the second command starts in the DONE cycle.
        issue(2'd0, 1'b0, 32'h00010000, 32'h00010000);
        wait_done("b2b_mul", 33, 0, 32'h00000001, 32'h00000000);
        issue(2'd1, 1'b0, 32'd50, 32'd8);
        wait_done("b2b_div", 33, 0, 32'd2, 32'd6);
        // MTHI in the DONE cycle overwrites the fresh remainder.
        md_op = 2'd2; rs_data = 32'hAAAA5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_in_done/hi", 64'(hi), 64'hAAAA5555);
        chk("mthi_in_done/lo", 64'(lo), 64'd6);
        chk("mthi_in_done/done", 64'(done), 64'd0);

        // Reset at iteration 10 aborts; a later MULTU runs normally.
        issue(2'd0, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_reset/busy", 64'(busy), 64'd0);
        chk("mid_reset/done", 64'(done), 64'd0);
        chk("mid_reset/hi", 64'(hi), 64'd0);
        chk("mid_reset/lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        chk("mid_reset/stays_idle", 64'(busy), 64'd0);
        issue(2'd0, 1'b0, 32'd3, 32'd4);
        wait_done("mul_after_reset", 33, 0, 32'd0, 32'd12);
        @(posedge clk); #1;

`ifdef MDU_SIGNED_EN
        issue(2'd1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("sdiv_m7_2", 34, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        @(posedge clk); #1;
        issue(2'd0, 1'b1, 32'hFFFFFFFE, 32'd3);
        wait_done("smul_m2_3", 34, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        @(posedge clk); #1;
`else
        // md_signed is ignored here, so the operands are treated as unsigned.
        issue(2'd1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("udiv_ignore_signed", 33, 0, 32'd1, 32'h7FFFFFFC);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
